// File: rtl/mor1kx_spr_cfg_port.sv
// Group-0 SPR configuration read port: fixed-latency registered ack, read-only
// words snapshotted at accept, with a sticky flag and saturating count of illegal writes.
module mor1kx_spr_cfg_port #(
    parameter int unsigned OPTION_READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] spr_bus_addr_i,
    input  logic        spr_bus_we_i,
    input  logic        spr_bus_stb_i,
    output logic [31:0] spr_bus_dat_o,
    output logic        spr_bus_ack_o,
    input  logic [31:0] spr_vr,
    input  logic [31:0] spr_upr,
    input  logic [31:0] spr_cpucfgr,
    input  logic [31:0] spr_dmmucfgr,
    input  logic [31:0] spr_immucfgr,
    input  logic [31:0] spr_dccfgr,
    input  logic [31:0] spr_iccfgr,
    input  logic [31:0] spr_dcfgr,
    input  logic [31:0] spr_pccfgr,
    input  logic [31:0] spr_vr2,
    input  logic [31:0] spr_avr,
    input  logic        wr_err_clr_i,
    output logic        wr_err_o,
    output logic [7:0]  wr_err_cnt_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned ERR_W  = 8;

    localparam logic [CNT_W-1:0] CNT_LOAD =
        (OPTION_READ_LATENCY > 1) ? CNT_W'(OPTION_READ_LATENCY - 2) : '0;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_DROP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               ack_q, ack_d;
    logic [DATA_W-1:0]  dat_q, dat_d;
    logic               wr_err_q, wr_err_d;
    logic [ERR_W-1:0]   wr_err_cnt_q, wr_err_cnt_d;

    logic               claimed_c;
    logic [DATA_W-1:0]  sel_word_c;

    assign claimed_c = (spr_bus_addr_i[15:4] == 12'd0);

    // Index decode on the low nibble; 11..15 are reserved and read as zero.
    always_comb begin
        sel_word_c = '0;
        case (spr_bus_addr_i[3:0])
            4'd0:    sel_word_c = spr_vr;
            4'd1:    sel_word_c = spr_upr;
            4'd2:    sel_word_c = spr_cpucfgr;
            4'd3:    sel_word_c = spr_dmmucfgr;
            4'd4:    sel_word_c = spr_immucfgr;
            4'd5:    sel_word_c = spr_dccfgr;
            4'd6:    sel_word_c = spr_iccfgr;
            4'd7:    sel_word_c = spr_dcfgr;
            4'd8:    sel_word_c = spr_pccfgr;
            4'd9:    sel_word_c = spr_vr2;
            4'd10:   sel_word_c = spr_avr;
            default: sel_word_c = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        data_d       = data_q;
        wr_err_d     = wr_err_q;
        wr_err_cnt_d = wr_err_cnt_q;
        ack_d        = 1'b0;
        dat_d        = '0;

        case (state_q)
            ST_IDLE: begin
                if (spr_bus_stb_i && claimed_c) begin
                    we_d   = spr_bus_we_i;
                    data_d = spr_bus_we_i ? '0 : sel_word_c;
                    if (OPTION_READ_LATENCY == 1) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_DROP;
            end
            ST_DROP: begin
                if (!spr_bus_stb_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear is applied before a coincident write-ack increment.
        if (wr_err_clr_i) begin
            wr_err_d     = 1'b0;
            wr_err_cnt_d = '0;
        end
        if ((state_q == ST_ACK) && we_q) begin
            wr_err_d = 1'b1;
            if (wr_err_cnt_d != ERR_MAX) begin
                wr_err_cnt_d = wr_err_cnt_d + ERR_W'(1);
            end
        end

        ack_d = (state_d == ST_ACK);
        dat_d = ack_d ? data_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            data_q       <= '0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            wr_err_q     <= 1'b0;
            wr_err_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            data_q       <= data_d;
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            wr_err_q     <= wr_err_d;
            wr_err_cnt_q <= wr_err_cnt_d;
        end
    end

    assign spr_bus_ack_o = ack_q;
    assign spr_bus_dat_o = dat_q;
    assign wr_err_o      = wr_err_q;
    assign wr_err_cnt_o  = wr_err_cnt_q;

endmodule
